rename_free_list: RTL and testbench
===================================

Name: rename_free_list

Overview:
- Physical-register free list for the 4-wide rename stage, directly upstream of the reorder buffer.
- Each cycle it supplies up to four free 8-bit physical register tags to rename. Rename forwards them as physReg0..3 together with the ROB insert mask.
- Committed instructions return their superseded physical tags on the release port.
- One checkpoint of the allocation pointer supports branch/exception rollback.

Parameters:
- NUM_PHYS, 128, total physical registers. Legal range 64..256.
- NUM_ARCH, 32, architectural registers. Tags p0..p(NUM_ARCH-1) are mapped at reset and are never in the list.
- DEPTH, NUM_PHYS-NUM_ARCH, free-list capacity. Derived; do not override.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low; clock clk
- alloc_req  in  4  lane i wants one tag (lane 0 = oldest)
- alloc_gnt  out  1  all requested lanes served this cycle
- alloc_phys0..alloc_phys3  out  8 each  tag for lane i; valid only when alloc_gnt=1 and alloc_req[i]=1
- release_valid  in  4  lane i returns a tag
- release_phys0..release_phys3  in  8 each  returned tags
- ckpt_take  in  1  snapshot the allocation pointer
- ckpt_restore  in  1  roll the allocation pointer back to the snapshot
- free_count  out  8  number of free entries (registered)
- overflow_err  out  1  sticky; set when a release would exceed DEPTH

Behaviour:
- Storage: circular buffer buf[DEPTH] of 8-bit tags, read pointer head, write pointer tail, register count.
- Pointer arithmetic is modulo DEPTH, which need not be a power of two: p+k >= DEPTH wraps to p+k-DEPTH.
- Reset (reset=0 at posedge):
  - buf[i] = NUM_ARCH+i for every i.
  - head=0, tail=0, count=DEPTH, ckpt_head=0.
  - overflow_err=0, free_count=DEPTH, alloc_gnt=0 for that cycle.
  - Reset asserted mid-operation discards all in-flight state; there is no partial restore.
- Allocation (combinational, zero latency):
  - n_req = popcount(alloc_req).
  - alloc_gnt = (n_req != 0) && (n_req <= count) && !ckpt_restore. All-or-nothing: there are no partial grants.
  - Requesting lanes take consecutive entries from head in lane order. Example: alloc_req=4'b1010 gives lane1 = buf[head] and lane3 = buf[head+1].
  - Non-requesting lanes output 0.
  - On grant, head advances by n_req at the clock edge.
- Release:
  - Valid lanes are compacted in lane order and written to buf[tail], buf[tail+1], ...
  - tail advances by popcount(release_valid).
  - Release is always accepted and has no backpressure.
  - If count + n_rel > DEPTH (n_rel = popcount(release_valid)), set overflow_err (sticky until reset) and drop the entire release: tail and buf are unchanged.
- Same-cycle alloc and release: the grant decision uses count before the release (no bypass). Next count = count - n_granted + n_rel_accepted.
- Checkpoint take:
  - ckpt_head <= head after this cycle's allocation.
  - ckpt_restore has priority: when both are asserted, take is ignored.
- Checkpoint restore:
  - head <= ckpt_head, and no allocation occurs that cycle.
  - count <= count + ((head - ckpt_head) mod DEPTH) + n_rel_accepted.
  - Releases in the same cycle are still accepted.
  - Tags handed out since the checkpoint become free again. Tags released since the checkpoint are unaffected because they sit at tail.
- free_count mirrors the count register, i.e. it shows the value after the last edge. Width 8 is sufficient because DEPTH <= 224.
- Empty list (count=0): alloc_gnt=0 for any request; releases proceed normally.
- Full list (count=DEPTH): any release sets overflow_err.
- A tag released twice is not detected. It is the upstream protocol's responsibility to prevent this.

Test Plan:
- Reset, then alloc_req=4'b1111 for one cycle -> alloc_gnt=1, tags 32,33,34,35; next cycle free_count=92.
- alloc_req=4'b0101 right after reset -> lane0=32, lane2=33, lanes 1 and 3 output 0; free_count 96->94.
- Allocate 4/cycle for 24 cycles -> free_count=0. Then alloc_req=4'b0001 -> alloc_gnt=0. Same cycle release_valid=4'b0011 with 40,41 -> free_count=2 next cycle. Next alloc_req=4'b0011 -> tags 40,41.
- Wrap check: after 24 full-allocate cycles, release 4 tags per cycle for 24 cycles. Pointers wrap at 96 (not 128). The next allocation returns the first released tag.
- ckpt_take when head=8, allocate 8 more (head=16), then ckpt_restore with alloc_req=4'b1111 and release_valid=4'b0001 -> alloc_gnt=0, head=8. free_count rises by 8+1. Next allocation returns tags 40..43 again.
- Immediately after reset, release_valid=4'b0001 -> overflow_err=1 from the next cycle and stays set; tail, free_count and the buffer are unchanged.

Source files
------------

// File: rtl/rename_free_list.sv
`default_nettype none
// ============================================================================
// Module   : rename_free_list
// Purpose  : Physical-register free list for the 4-wide rename stage. It holds
//            the tags that are currently unmapped in a circular buffer whose
//            size need not be a power of two. Each cycle it hands out up to
//            four tags and takes back up to four superseded tags from commit.
//            It keeps one checkpoint of the allocation pointer so that
//            speculative allocations can be rolled back.
// Ports    : clk, reset (synchronous, active-low)
//            i_alloc_req[3:0]         lanes requesting a tag (lane 0 oldest)
//            o_alloc_gnt              every requesting lane is served
//            o_alloc_phys0..3         granted tag per lane, 0 on idle lanes
//            i_release_valid[3:0]     lanes returning a tag
//            i_release_phys0..3       returned tags
//            i_ckpt_take              snapshot the allocation pointer
//            i_ckpt_restore           roll the allocation pointer back
//            o_free_count             free entries after the last edge
//            o_overflow_err           sticky release-overflow flag
// Revision : 1.0 - initial release
// ============================================================================
module rename_free_list #(
  parameter int unsigned NUM_PHYS = 128,
  parameter int unsigned NUM_ARCH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_alloc_req,
  output logic       o_alloc_gnt,
  output logic [7:0] o_alloc_phys0,
  output logic [7:0] o_alloc_phys1,
  output logic [7:0] o_alloc_phys2,
  output logic [7:0] o_alloc_phys3,
  input  logic [3:0] i_release_valid,
  input  logic [7:0] i_release_phys0,
  input  logic [7:0] i_release_phys1,
  input  logic [7:0] i_release_phys2,
  input  logic [7:0] i_release_phys3,
  input  logic       i_ckpt_take,
  input  logic       i_ckpt_restore,
  output logic [7:0] o_free_count,
  output logic       o_overflow_err
);

  localparam int unsigned DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned TAG_W = 8;

  localparam logic [PW:0] c_DEPTH_X   = (PW+1)'(DEPTH);
  localparam logic [7:0]  c_DEPTH_CNT = 8'(DEPTH);

  function automatic logic [2:0] f_pop4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  // Advance a pointer by k (k <= 4) with wrap at DEPTH rather than 2**PW.
  function automatic logic [PW-1:0] f_adv(input logic [PW-1:0] p, input logic [2:0] k);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(k);
    if (s >= c_DEPTH_X) begin
      s = s - c_DEPTH_X;
    end
    return s[PW-1:0];
  endfunction

  logic [TAG_W-1:0] r_buf [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW-1:0]    r_ckpt;
  logic [7:0]       r_count;
  logic             r_ovf;

  logic [2:0]       w_n_req;
  logic [2:0]       w_n_rel;
  logic             w_gnt;
  logic             w_rel_ovf;
  logic             w_rel_acc;
  logic [7:0]       w_dist;
  logic [7:0]       w_rel_add;
  logic [PW-1:0]    w_head_nxt;
  logic [7:0]       w_count_nxt;
  logic [TAG_W-1:0] w_phys    [4];
  logic [TAG_W-1:0] w_rel_tag [4];
  logic [PW-1:0]    w_rd_idx  [4];
  logic [PW-1:0]    w_wr_idx  [4];

  assign w_rel_tag[0] = i_release_phys0;
  assign w_rel_tag[1] = i_release_phys1;
  assign w_rel_tag[2] = i_release_phys2;
  assign w_rel_tag[3] = i_release_phys3;

  assign w_n_req = f_pop4(i_alloc_req);
  assign w_n_rel = f_pop4(i_release_valid);

  // Grant looks at the count before this cycle's releases; holding reset
  // low suppresses the grant so nothing is handed out during reset.
  assign w_gnt = reset && (w_n_req != 3'd0) && (8'(w_n_req) <= r_count) && !i_ckpt_restore;

  // A release that would overfill the list is dropped as a whole.
  assign w_rel_ovf = (w_n_rel != 3'd0) && ((r_count + 8'(w_n_rel)) > c_DEPTH_CNT);
  assign w_rel_acc = (w_n_rel != 3'd0) && !w_rel_ovf;
  assign w_rel_add = w_rel_acc ? 8'(w_n_rel) : 8'd0;

  // Entries handed out since the checkpoint, i.e. (head - ckpt) mod DEPTH.
  always_comb begin
    w_dist = 8'd0;
    if (r_head >= r_ckpt) begin
      w_dist = 8'(r_head - r_ckpt);
    end else begin
      w_dist = 8'(({1'b0, r_head} + c_DEPTH_X) - {1'b0, r_ckpt});
    end
  end

  // Lane i uses the slot given by how many lower lanes are active, which
  // packs the active lanes onto consecutive buffer entries.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [3:0] c_LOWER = 4'((1 << gi) - 1);
    assign w_rd_idx[gi] = f_adv(r_head, f_pop4(i_alloc_req & c_LOWER));
    assign w_wr_idx[gi] = f_adv(r_tail, f_pop4(i_release_valid & c_LOWER));
    assign w_phys[gi]   = i_alloc_req[gi] ? r_buf[w_rd_idx[gi]] : '0;
  end

  always_comb begin
    w_head_nxt  = r_head;
    w_count_nxt = r_count + w_rel_add;
    if (i_ckpt_restore) begin
      w_head_nxt  = r_ckpt;
      w_count_nxt = r_count + w_dist + w_rel_add;
    end else if (w_gnt) begin
      w_head_nxt  = f_adv(r_head, w_n_req);
      w_count_nxt = r_count - 8'(w_n_req) + w_rel_add;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_buf[i] <= TAG_W'(NUM_ARCH + i);
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_ckpt  <= '0;
      r_count <= c_DEPTH_CNT;
      r_ovf   <= 1'b0;
    end else begin
      r_head  <= w_head_nxt;
      r_count <= w_count_nxt;
      // Restore wins over take; the snapshot is the post-allocation head.
      if (i_ckpt_take && !i_ckpt_restore) begin
        r_ckpt <= w_head_nxt;
      end
      if (w_rel_ovf) begin
        r_ovf <= 1'b1;
      end
      if (w_rel_acc) begin
        r_tail <= f_adv(r_tail, w_n_rel);
        for (int l = 0; l < 4; l++) begin
          if (i_release_valid[l]) begin
            r_buf[w_wr_idx[l]] <= w_rel_tag[l];
          end
        end
      end
    end
  end

  assign o_alloc_gnt    = w_gnt;
  assign o_alloc_phys0  = w_phys[0];
  assign o_alloc_phys1  = w_phys[1];
  assign o_alloc_phys2  = w_phys[2];
  assign o_alloc_phys3  = w_phys[3];
  assign o_free_count   = r_count;
  assign o_overflow_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rename_free_list.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_free_list
// Purpose  : Self-checking bench for rename_free_list. A queue-based model
//            holds the free tags in hand-out order, plus the tags handed out
//            since the last checkpoint, and predicts grant, lane tags,
//            free count and the overflow flag every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rename_free_list;

  localparam int DEPTH = 96;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] i_alloc_req = '0;
  logic       o_alloc_gnt;
  logic [7:0] o_alloc_phys0, o_alloc_phys1, o_alloc_phys2, o_alloc_phys3;
  logic [3:0] i_release_valid = '0;
  logic [7:0] i_release_phys0 = '0, i_release_phys1 = '0;
  logic [7:0] i_release_phys2 = '0, i_release_phys3 = '0;
  logic       i_ckpt_take = 1'b0;
  logic       i_ckpt_restore = 1'b0;
  logic [7:0] o_free_count;
  logic       o_overflow_err;

  always #5 clk = ~clk;

  rename_free_list #(.NUM_PHYS(128), .NUM_ARCH(32)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .i_alloc_req    (i_alloc_req),
    .o_alloc_gnt    (o_alloc_gnt),
    .o_alloc_phys0  (o_alloc_phys0),
    .o_alloc_phys1  (o_alloc_phys1),
    .o_alloc_phys2  (o_alloc_phys2),
    .o_alloc_phys3  (o_alloc_phys3),
    .i_release_valid(i_release_valid),
    .i_release_phys0(i_release_phys0),
    .i_release_phys1(i_release_phys1),
    .i_release_phys2(i_release_phys2),
    .i_release_phys3(i_release_phys3),
    .i_ckpt_take    (i_ckpt_take),
    .i_ckpt_restore (i_ckpt_restore),
    .o_free_count   (o_free_count),
    .o_overflow_err (o_overflow_err)
  );

  logic [7:0] w_lane [4];
  assign w_lane[0] = o_alloc_phys0;
  assign w_lane[1] = o_alloc_phys1;
  assign w_lane[2] = o_alloc_phys2;
  assign w_lane[3] = o_alloc_phys3;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: free tags in hand-out order, tags handed out since the
  // checkpoint (speculative) and tags handed out before it (committed).
  int m_free [$];
  int m_spec [$];
  int m_comm [$];
  bit m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void drop_from_pools(input int t);
    for (int i = 0; i < m_comm.size(); i++) if (m_comm[i] == t) begin m_comm.delete(i); return; end
    for (int i = 0; i < m_spec.size(); i++) if (m_spec[i] == t) begin m_spec.delete(i); return; end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    i_alloc_req = 4'b1111;
    i_release_valid = '0;
    i_ckpt_take = 1'b0;
    i_ckpt_restore = 1'b0;
    #1;
    check_eq("rst_gnt", 32'(o_alloc_gnt), 0);
    @(posedge clk);
    #1;
    check_eq("rst_free_count", 32'(o_free_count), DEPTH);
    check_eq("rst_ovf", 32'(o_overflow_err), 0);
    @(negedge clk);
    reset = 1'b1;
    i_alloc_req = '0;
    m_free.delete();
    m_spec.delete();
    m_comm.delete();
    m_ovf = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_free.push_back(32 + i);
  endtask

  // One clock: drive, check outputs before the edge, then advance the model.
  task automatic step(input logic [3:0] req, input logic [3:0] rv, input logic [31:0] rtags,
                      input logic take, input logic restore);
    int  nreq, nrel, k;
    bit  gnt, acc;
    @(negedge clk);
    i_alloc_req     = req;
    i_release_valid = rv;
    i_release_phys0 = rtags[7:0];
    i_release_phys1 = rtags[15:8];
    i_release_phys2 = rtags[23:16];
    i_release_phys3 = rtags[31:24];
    i_ckpt_take     = take;
    i_ckpt_restore  = restore;
    #1;
    nreq = $countones(req);
    nrel = $countones(rv);
    gnt  = (nreq != 0) && (nreq <= m_free.size()) && !restore;
    check_eq("gnt", 32'(o_alloc_gnt), 32'(gnt));
    check_eq("free_count", 32'(o_free_count), m_free.size());
    check_eq("overflow_err", 32'(o_overflow_err), 32'(m_ovf));
    k = 0;
    for (int l = 0; l < 4; l++) begin
      if (req[l]) begin
        if (gnt) check_eq($sformatf("lane%0d_tag", l), 32'(w_lane[l]), m_free[k]);
        k++;
      end else begin
        check_eq($sformatf("lane%0d_idle", l), 32'(w_lane[l]), 0);
      end
    end
    @(posedge clk);
    #1;
    acc = (nrel != 0) && (m_free.size() + nrel <= DEPTH);
    if (nrel != 0 && !acc) m_ovf = 1'b1;
    if (restore) begin
      for (int i = m_spec.size() - 1; i >= 0; i--) m_free.push_front(m_spec[i]);
      m_spec.delete();
    end else if (gnt) begin
      for (int i = 0; i < nreq; i++) m_spec.push_back(m_free.pop_front());
    end
    if (acc) begin
      for (int l = 0; l < 4; l++) begin
        if (rv[l]) begin
          m_free.push_back(int'(rtags[8*l +: 8]));
          drop_from_pools(int'(rtags[8*l +: 8]));
        end
      end
    end
    if (take && !restore) begin
      foreach (m_spec[i]) m_comm.push_back(m_spec[i]);
      m_spec.delete();
    end
    i_alloc_req = '0;
    i_release_valid = '0;
    i_ckpt_take = 1'b0;
    i_ckpt_restore = 1'b0;
  endtask

  // Combinational look at the lane tags without clocking.
  task automatic probe(input string tag, input logic [3:0] req, input logic [31:0] exp);
    i_alloc_req = req;
    #1;
    for (int l = 0; l < 4; l++)
      check_eq($sformatf("%s_lane%0d", tag, l), 32'(w_lane[l]), 32'(exp[8*l +: 8]));
    i_alloc_req = '0;
  endtask

  initial begin
    // Full four-wide allocation right after reset.
    do_reset();
    probe("first4", 4'b1111, {8'd35, 8'd34, 8'd33, 8'd32});
    step(4'b1111, 4'b0000, 32'd0, 1'b0, 1'b0);
    check_eq("first4_fc", 32'(o_free_count), 92);

    // Sparse lanes pack onto consecutive entries.
    do_reset();
    probe("sparse", 4'b0101, {8'd0, 8'd33, 8'd0, 8'd32});
    step(4'b0101, 4'b0000, 32'd0, 1'b0, 1'b0);
    check_eq("sparse_fc", 32'(o_free_count), 94);

    // Drain to empty, denied request with a same-cycle release.
    do_reset();
    for (int c = 0; c < 24; c++) step(4'b1111, 4'b0000, 32'd0, 1'b0, 1'b0);
    check_eq("empty_fc", 32'(o_free_count), 0);
    step(4'b0001, 4'b0011, {8'd0, 8'd0, 8'd41, 8'd40}, 1'b0, 1'b0);
    check_eq("empty_rel_fc", 32'(o_free_count), 2);
    probe("after_empty", 4'b0011, {8'd0, 8'd0, 8'd41, 8'd40});
    step(4'b0011, 4'b0000, 32'd0, 1'b0, 1'b0);

    // Pointer wrap at 96: release everything back in reverse order.
    do_reset();
    for (int c = 0; c < 24; c++) step(4'b1111, 4'b0000, 32'd0, 1'b0, 1'b0);
    for (int c = 0; c < 24; c++) begin
      logic [31:0] t;
      for (int l = 0; l < 4; l++) t[8*l +: 8] = 8'(127 - (c*4 + l));
      step(4'b0000, 4'b1111, t, 1'b0, 1'b0);
    end
    check_eq("wrap_fc", 32'(o_free_count), 96);
    probe("wrap", 4'b0001, {8'd0, 8'd0, 8'd0, 8'd127});
    for (int c = 0; c < 6; c++) step(4'b1111, 4'b0000, 32'd0, 1'b0, 1'b0);

    // Checkpoint at head=8, allocate 8 more, restore with one release.
    do_reset();
    step(4'b1111, 4'b0000, 32'd0, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 32'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 32'd0, 1'b1, 1'b0);
    step(4'b1111, 4'b0000, 32'd0, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 32'd0, 1'b0, 1'b0);
    check_eq("ckpt_pre_fc", 32'(o_free_count), 80);
    step(4'b1111, 4'b0001, {24'd0, 8'd32}, 1'b0, 1'b1);
    check_eq("ckpt_post_fc", 32'(o_free_count), 89);
    probe("ckpt", 4'b1111, {8'd43, 8'd42, 8'd41, 8'd40});
    step(4'b1111, 4'b0000, 32'd0, 1'b0, 1'b0);

    // Release into a full list: sticky error, release dropped.
    do_reset();
    step(4'b0000, 4'b0001, {24'd0, 8'd50}, 1'b0, 1'b0);
    check_eq("ovf_set", 32'(o_overflow_err), 1);
    check_eq("ovf_fc", 32'(o_free_count), 96);
    for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 32'd0, 1'b0, 1'b0);
    check_eq("ovf_sticky", 32'(o_overflow_err), 1);
    probe("ovf_buf", 4'b1111, {8'd35, 8'd34, 8'd33, 8'd32});
    step(4'b1111, 4'b0000, 32'd0, 1'b0, 1'b0);

    // Randomized traffic under a legal release protocol.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0]  req, rv;
      logic [31:0] t;
      logic        take, rst_ck;
      int          n, idx, lane;
      req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) req = 4'b1111;
      take   = ($urandom_range(0, 7) == 0);
      rst_ck = ($urandom_range(0, 9) == 0) && (m_spec.size() < DEPTH);
      n = $urandom_range(0, 4);
      if (n > m_comm.size()) n = m_comm.size();
      rv = '0;
      t  = '0;
      while ($countones(rv) < n) begin
        lane = $urandom_range(0, 3);
        if (!rv[lane]) begin
          rv[lane] = 1'b1;
          idx = $urandom_range(0, m_comm.size() - 1);
          t[8*lane +: 8] = 8'(m_comm[idx]);
          m_comm.delete(idx);
        end
      end
      step(req, rv, t, take, rst_ck);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
